data_mem_latency: RTL and testbench

- Parametrised successor to the 64-bit datapath's single-cycle data memory.
- Adds a valid/ready request handshake, a configurable access latency, and sized little-endian loads/stores (byte/half/word/double) with sign/zero extension.
- Reports misaligned accesses.
- Sits between the datapath MEM stage and the backing array; the datapath stalls while req_ready or resp_valid is low.

---
 rtl/data_mem_latency.sv | 177 +++++++++++++++++
 tb/tb_data_mem_latency.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_latency.sv
// data_mem_latency: doubleword-organised data memory with a valid/ready
// request handshake, a fixed programmable access latency, sized
// little-endian loads/stores with sign/zero extension and misalignment
// reporting.
module data_mem_latency #(
    parameter int DEPTH_DW = 256,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        misalign_err,
    output logic        busy
);

    localparam int         IDX_W = $clog2(DEPTH_DW);
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              init_q, init_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [IDX_W+2:0]  addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              merr_q, merr_d;

    logic [63:0]       mem_q [DEPTH_DW];

    logic [IDX_W-1:0]  idx;
    logic [2:0]        off;
    logic              misalign;
    logic [7:0]        be;
    logic [63:0]       wdata_sh;
    logic [63:0]       rd_sh;
    logic [63:0]       load_val;

    // Address bits above the array index alias onto the same doubleword.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr[63:IDX_W+3];

    assign req_ready    = init_q && (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = rdata_q;
    assign misalign_err = merr_q;

    // Decode the latched request into lane enables, aligned store data and the extended load value.
    always_comb begin
        idx      = addr_q[IDX_W+2:3];
        off      = addr_q[2:0];
        misalign = 1'b0;
        be       = 8'h00;
        case (size_q)
            2'd0: begin misalign = 1'b0;          be = 8'h01; end
            2'd1: begin misalign = addr_q[0];     be = 8'h03; end
            2'd2: begin misalign = |addr_q[1:0];  be = 8'h0F; end
            default: begin misalign = |addr_q[2:0]; be = 8'hFF; end
        endcase
        be       = be << off;
        wdata_sh = wdata_q << {off, 3'b000};
        rd_sh    = mem_q[idx] >> {off, 3'b000};
        load_val = rd_sh;
        case (size_q)
            2'd0: load_val = signed_q ? {{56{rd_sh[7]}},  rd_sh[7:0]}  : {56'd0, rd_sh[7:0]};
            2'd1: load_val = signed_q ? {{48{rd_sh[15]}}, rd_sh[15:0]} : {48'd0, rd_sh[15:0]};
            2'd2: load_val = signed_q ? {{32{rd_sh[31]}}, rd_sh[31:0]} : {32'd0, rd_sh[31:0]};
            default: load_val = rd_sh;
        endcase
    end

    // Next-state logic: accept in IDLE, count down the latency, commit once, respond once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        init_d   = 1'b1;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = 64'd0;
        merr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr[IDX_W+2:0];
                    wdata_d  = req_wdata;
                    cnt_d    = LAT4;
                    if (LATENCY == 0) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = RESP;
                merr_d  = misalign;
                if (!write_q && !misalign) begin
                    rdata_d = load_val;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            init_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 64'd0;
            rdata_q  <= 64'd0;
            merr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merr_q   <= merr_d;
        end
    end

    // Byte-lane store at the edge leaving COMMIT; suppressed by reset or misalignment.
    always_ff @(posedge clk) begin
        if (rst && (state_q == COMMIT) && write_q && !misalign) begin
            for (int k = 0; k < 8; k++) begin
                if (be[k]) begin
                    mem_q[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_latency.sv
// tb_data_mem_latency: directed and randomized checks of data_mem_latency
// against a byte-array reference model. Instance 0 uses LATENCY=2,
// instance 1 uses LATENCY=0; both have DEPTH_DW=256.
module tb_data_mem_latency;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [1:0]  req_size     [2];
    logic        req_signed   [2];
    logic [63:0] req_addr     [2];
    logic [63:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic [63:0] resp_rdata   [2];
    logic        misalign_err [2];
    logic        busy         [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [2][DEPTH*8];

    data_mem_latency #(.DEPTH_DW(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .misalign_err(misalign_err[0]),
        .busy(busy[0])
    );

    data_mem_latency #(.DEPTH_DW(DEPTH), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .misalign_err(misalign_err[1]),
        .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, asserts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: memory as a flat byte array, wrapping modulo its size.
    function automatic void modelAccess(input int d, input bit wr, input logic [1:0] sz,
                                        input bit sg, input logic [63:0] addr,
                                        input logic [63:0] wd, output logic [63:0] rd,
                                        output bit me);
        int nb;
        int base;
        nb   = 1 << sz;
        base = int'(addr[10:0]);
        rd   = 64'd0;
        me   = (base % nb) != 0;
        if (me) return;
        if (wr) begin
            for (int k = 0; k < nb; k++) mdl[d][base+k] = wd[8*k +: 8];
        end else begin
            for (int k = 0; k < nb; k++) rd[8*k +: 8] = mdl[d][base+k];
            if (sg && nb < 8 && rd[8*nb-1]) rd = rd | ~((64'd1 << (8*nb)) - 64'd1);
        end
    endfunction

    // Issue one request and follow it to its response, recording what was seen.
    task automatic applyStimulus(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                                 input logic [63:0] addr, input logic [63:0] wd,
                                 output logic [63:0] rd, output logic me,
                                 output int resp_cyc, output int ready_low);
        @(negedge clk);
        checkOutput("ready_before_req", 64'(req_ready[d]), 64'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        req_write[d]  = 1'($urandom);
        req_addr[d]   = {$urandom, $urandom};
        req_wdata[d]  = {$urandom, $urandom};
        resp_cyc  = 0;
        ready_low = 0;
        rd = 64'd0;
        me = 1'b0;
        for (int n = 1; n <= 40 && resp_cyc == 0; n++) begin
            @(negedge clk);
            if (!req_ready[d]) ready_low++;
            checkOutput("busy_in_flight", 64'(busy[d]), 64'd1);
            if (resp_valid[d]) begin
                resp_cyc = n;
                rd = resp_rdata[d];
                me = misalign_err[d];
            end else begin
                checkOutput("rdata_zero_outside_resp", resp_rdata[d], 64'd0);
                checkOutput("merr_zero_outside_resp", 64'(misalign_err[d]), 64'd0);
            end
        end
        checkOutput("resp_seen_before_timeout", 64'(resp_cyc != 0), 64'd1);
        @(negedge clk);
        checkOutput("resp_one_cycle_pulse", 64'(resp_valid[d]), 64'd0);
        checkOutput("busy_after_resp", 64'(busy[d]), 64'd0);
    endtask

    // Model-checked access; returns the observed load data for directed literal checks.
    task automatic runAccess(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                             input logic [63:0] addr, input logic [63:0] wd,
                             output logic [63:0] rd, output logic me);
        logic [63:0] exp_rd;
        bit          exp_me;
        int          cyc;
        int          rlow;
        int          lat;
        lat = (d == 0) ? LAT_A : LAT_B;
        modelAccess(d, wr, sz, sg, addr, wd, exp_rd, exp_me);
        applyStimulus(d, wr, sz, sg, addr, wd, rd, me, cyc, rlow);
        checkOutput("resp_rdata", rd, exp_rd);
        checkOutput("misalign_err", 64'(me), 64'(exp_me));
        checkOutput("resp_cycle_after_accept", 64'(cyc), 64'(lat + 2));
        checkOutput("req_ready_low_cycles", 64'(rlow), 64'(lat + 2));
    endtask

    localparam logic [63:0] PAT = 64'h1122334455667788;

    initial begin
        logic [63:0] rd;
        logic        me;
        logic [63:0] a;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
            req_signed[d] = 1'b0; req_addr[d] = 64'd0; req_wdata[d] = 64'd0;
        end

        // Reset held with a pending request.
        $display("[TB] reset phase");
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'd3;
            req_addr[d] = 64'h10; req_wdata[d] = 64'hFFFF_0000_FFFF_0000;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checkOutput("reset_req_ready", 64'(req_ready[d]), 64'd0);
                checkOutput("reset_busy", 64'(busy[d]), 64'd0);
                checkOutput("reset_resp_valid", 64'(resp_valid[d]), 64'd0);
                checkOutput("reset_resp_rdata", resp_rdata[d], 64'd0);
                checkOutput("reset_misalign", 64'(misalign_err[d]), 64'd0);
            end
        end
        rst = 1'b1;
        for (int d = 0; d < 2; d++) req_valid[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkOutput("ready_after_release", 64'(req_ready[d]), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) checkOutput("no_resp_for_held_req", 64'(resp_valid[d]), 64'd0);
        end

        // Doubleword store and load.
        $display("[TB] directed store/load, LATENCY=2");
        runAccess(0, 1'b1, 2'd3, 1'b0, 64'h10, PAT, rd, me);
        runAccess(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd, me);
        checkOutput("load_double_0x10", rd, PAT);

        // Sized loads with extension.
        runAccess(0, 1'b0, 2'd0, 1'b1, 64'h10, 64'd0, rd, me);
        checkOutput("load_byte_signed", rd, 64'hFFFF_FFFF_FFFF_FF88);
        runAccess(0, 1'b0, 2'd0, 1'b0, 64'h10, 64'd0, rd, me);
        checkOutput("load_byte_unsigned", rd, 64'h0000_0000_0000_0088);
        runAccess(0, 1'b0, 2'd1, 1'b1, 64'h16, 64'd0, rd, me);
        checkOutput("load_half_signed", rd, 64'h0000_0000_0000_1122);
        runAccess(0, 1'b0, 2'd2, 1'b0, 64'h14, 64'd0, rd, me);
        checkOutput("load_word_unsigned", rd, 64'h0000_0000_1122_3344);

        // Misaligned store leaves memory intact.
        runAccess(0, 1'b1, 2'd2, 1'b0, 64'h12, 64'hDEAD_BEEF, rd, me);
        checkOutput("misaligned_store_err", 64'(me), 64'd1);
        runAccess(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd, me);
        checkOutput("load_after_misaligned", rd, PAT);

        // Reset during WAIT aborts the store.
        $display("[TB] abort phase");
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd3;
        req_signed[0] = 1'b0; req_addr[0] = 64'h10; req_wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_wait_busy", 64'(busy[0]), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy_cleared", 64'(busy[0]), 64'd0);
        checkOutput("abort_resp_valid", 64'(resp_valid[0]), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abort_no_response", 64'(resp_valid[0]), 64'd0);
        end
        runAccess(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd, me);
        checkOutput("load_after_abort", rd, PAT);

        // LATENCY=0 instance with index aliasing.
        $display("[TB] wrap phase, LATENCY=0");
        runAccess(1, 1'b1, 2'd3, 1'b0, 64'h10, PAT, rd, me);
        runAccess(1, 1'b0, 2'd3, 1'b0, 64'h810, 64'd0, rd, me);
        checkOutput("load_wrap_0x810", rd, PAT);

        // Randomized mix over a pre-filled 128-byte region, high bits random.
        $display("[TB] random phase");
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                a = {$urandom, $urandom};
                a[10:0] = 11'(i * 8);
                runAccess(d, 1'b1, 2'd3, 1'b0, a, {$urandom, $urandom}, rd, me);
            end
            for (int i = 0; i < 40; i++) begin
                a = {$urandom, $urandom};
                a[10:7] = 4'd0;
                runAccess(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rd, me);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
